iz_param_loader: RTL and testbench

IZ_PARAM_LOADER -- requirements
Module: iz_param_loader

---
 rtl/iz_pkg.sv | 20 ++
 rtl/iz_param_loader.sv | 150 +++++++++++++++
 tb/tb_iz_param_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/iz_pkg.sv
// rtl/iz_pkg.sv - shared constants and FSM state type for the neuron parameter loader
package iz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_CSUM   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } iz_state_t;

    localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
    localparam int          FRAME_DATA_BYTES = 8;

    localparam logic [15:0] IZ_DEF_A = 16'h0001;
    localparam logic [15:0] IZ_DEF_B = 16'h000D;
    localparam logic [15:0] IZ_DEF_C = 16'hEFC0;
    localparam logic [15:0] IZ_DEF_D = 16'h0200;

endpackage

// File: rtl/iz_param_loader.sv
// rtl/iz_param_loader.sv - framed byte loader committing XOR-checked neuron parameters
module iz_param_loader
    import iz_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] DEF_A          = IZ_DEF_A,
    parameter logic [15:0] DEF_B          = IZ_DEF_B,
    parameter logic [15:0] DEF_C          = IZ_DEF_C,
    parameter logic [15:0] DEF_D          = IZ_DEF_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        load_done,
    output logic        load_error
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_IX = 3'(FRAME_DATA_BYTES - 1);

    iz_state_t       state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      xor_q, xor_d;
    logic [TW-1:0]   to_q, to_d;
    logic [7:0][7:0] shadow_q, shadow_d;
    logic [15:0]     param_a_q, param_a_d, param_b_q, param_b_d;
    logic [15:0]     param_c_q, param_c_d, param_d_q, param_d_d;
    logic            params_ready_q, params_ready_d;
    logic            have_set_q, have_set_d;
    logic            in_ready_q, in_ready_d;
    logic            load_done_q, load_done_d;
    logic            load_error_q, load_error_d;
    logic            accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        xor_d          = xor_q;
        to_d           = to_q;
        shadow_d       = shadow_q;
        param_a_d      = param_a_q;
        param_b_d      = param_b_q;
        param_c_d      = param_c_q;
        param_d_d      = param_d_q;
        params_ready_d = params_ready_q;
        have_set_d     = have_set_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d        = ST_RECV;
                    cnt_d          = 3'd0;
                    xor_d          = 8'h00;
                    to_d           = '0;
                    params_ready_d = 1'b0;
                end
            end
            ST_RECV, ST_CSUM: begin
                // An accepted byte always wins over a timeout in the same cycle.
                if (accept) begin
                    to_d = '0;
                    if (state_q == ST_RECV) begin
                        shadow_d[cnt_q] = in_data;
                        xor_d           = xor_q ^ in_data;
                        cnt_d           = cnt_q + 3'd1;
                        if (cnt_q == LAST_IX) state_d = ST_CSUM;
                    end else if (in_data == xor_q) begin
                        state_d        = ST_COMMIT;
                        param_a_d      = {shadow_q[0], shadow_q[1]};
                        param_b_d      = {shadow_q[2], shadow_q[3]};
                        param_c_d      = {shadow_q[4], shadow_q[5]};
                        param_d_d      = {shadow_q[6], shadow_q[7]};
                        params_ready_d = 1'b1;
                        have_set_d     = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_ERR;
                end else if (to_q != '1) begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_ERR: begin
                state_d        = ST_IDLE;
                params_ready_d = have_set_q;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_RECV) || (state_d == ST_CSUM);
        load_done_d  = (state_d == ST_COMMIT);
        load_error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            xor_q          <= 8'h00;
            to_q           <= '0;
            shadow_q       <= '0;
            param_a_q      <= DEF_A;
            param_b_q      <= DEF_B;
            param_c_q      <= DEF_C;
            param_d_q      <= DEF_D;
            params_ready_q <= 1'b0;
            have_set_q     <= 1'b0;
            in_ready_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            xor_q          <= xor_d;
            to_q           <= to_d;
            shadow_q       <= shadow_d;
            param_a_q      <= param_a_d;
            param_b_q      <= param_b_d;
            param_c_q      <= param_c_d;
            param_d_q      <= param_d_d;
            params_ready_q <= params_ready_d;
            have_set_q     <= have_set_d;
            in_ready_q     <= in_ready_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign param_a      = param_a_q;
    assign param_b      = param_b_q;
    assign param_c      = param_c_q;
    assign param_d      = param_d_q;
    assign params_ready = params_ready_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;

endmodule

// File: tb/tb_iz_param_loader.sv
// tb/tb_iz_param_loader.sv - directed table-driven bench for iz_param_loader
module tb_iz_param_loader;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        params_ready;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    iz_param_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          npre;
        logic [23:0] pre;
        logic [63:0] data;
        logic [7:0]  csum;
        logic        ok;
        logic [63:0] exp_p;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] params();
        return {param_a, param_b, param_c, param_d};
    endfunction

    // gap = number of clock edges with in_valid low before this byte; returns 1 time unit after the transfer edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends sync + data + checksum; gap_ix selects one byte (8 = checksum) preceded by a T-1 idle gap.
    task automatic run_frame(input string tag, input logic [63:0] data, input logic [7:0] csum,
                             input logic ok, input logic [63:0] exp_p, input logic exp_ready,
                             input int max_gap, input int gap_ix);
        logic [63:0] prev;
        int g;
        prev = params();
        send_byte(8'hA5, 0);
        chk({tag, "_ready_after_sync"}, 64'(params_ready), 64'd0);
        for (int i = 0; i < 8; i++) begin
            g = (i == gap_ix) ? T - 1 : $urandom_range(0, max_gap);
            send_byte(data[63-8*i -: 8], g);
        end
        chk({tag, "_no_partial"}, params(), prev);
        chk({tag, "_ready_in_frame"}, 64'(params_ready), 64'd0);
        send_byte(csum, (gap_ix == 8) ? T - 1 : $urandom_range(0, max_gap));
        chk({tag, "_pulses"}, {62'd0, load_done, load_error}, {62'd0, ok, ~ok});
        chk({tag, "_params"}, params(), exp_p);
        chk({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulses_end"}, {62'd0, load_done, load_error}, 64'd0);
        chk({tag, "_ready_after"}, {62'd0, params_ready, in_ready}, {62'd0, exp_ready, 1'b1});
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{npre: 0, pre: 24'h0, data: 64'h0002_000D_EFC0_0200, csum: 8'h21, ok: 1'b0,
                    exp_p: 64'h0001_000D_EFC0_0200, exp_ready: 1'b0};
        vecs[1] = '{npre: 0, pre: 24'h0, data: 64'h0002_000D_EFC0_0200, csum: 8'h22, ok: 1'b1,
                    exp_p: 64'h0002_000D_EFC0_0200, exp_ready: 1'b1};
        vecs[2] = '{npre: 3, pre: 24'h00FF13, data: 64'h1234_A55A_8001_7FFE, csum: 8'hD9, ok: 1'b1,
                    exp_p: 64'h1234_A55A_8001_7FFE, exp_ready: 1'b1};
        vecs[3] = '{npre: 0, pre: 24'h0, data: 64'h1111_2222_3333_4444, csum: 8'h01, ok: 1'b0,
                    exp_p: 64'h1234_A55A_8001_7FFE, exp_ready: 1'b1};

        do_reset();
        chk("reset_params", params(), 64'h0001_000D_EFC0_0200);
        chk("reset_flags", {60'd0, in_ready, params_ready, load_done, load_error}, 64'h8);

        for (int v = 0; v < 4; v++) begin
            for (int p = 0; p < vecs[v].npre; p++) begin
                send_byte(vecs[v].pre[23-8*p -: 8], 0);
                chk($sformatf("v%0d_pre%0d_idle", v, p), {62'd0, load_done, load_error}, 64'd0);
            end
            run_frame($sformatf("v%0d", v), vecs[v].data, vecs[v].csum, vecs[v].ok,
                      vecs[v].exp_p, vecs[v].exp_ready, (v >= 2) ? 3 : 0, -1);
        end

        // Timeout: sync + 3 bytes then silence; error arrives T idle edges after the last byte.
        send_byte(8'hA5, 0);
        chk("to_ready_in_frame", 64'(params_ready), 64'd0);
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        send_byte(8'h77, 0);
        n = 0;
        while (n < 3 * T) begin
            @(negedge clk);
            n++;
            if (load_error || load_done) break;
        end
        chk("to_latency", 64'(n), 64'(T + 1));
        chk("to_pulse", {62'd0, load_done, load_error}, 64'd1);
        chk("to_params_kept", params(), 64'h1234_A55A_8001_7FFE);
        @(negedge clk);
        chk("to_ready_restored", {62'd0, params_ready, load_error}, 64'h2);

        // A byte arriving on the final timeout cycle is accepted instead of aborting.
        run_frame("edge_gap", 64'h0A0B_0C0D_0E0F_1011, 8'h00, 1'b1, 64'h0A0B_0C0D_0E0F_1011, 1'b1, 0, 3);
        run_frame("edge_gap_cs", 64'h0102_0304_0506_0708, 8'h08, 1'b1, 64'h0102_0304_0506_0708, 1'b1, 0, 8);

        // Reset after the 5th data byte drops the partial frame; leftover bytes without sync are ignored.
        send_byte(8'hA5, 0);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 2);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 3);
        send_byte(8'h33, 1);
        do_reset();
        chk("rst_mid_params", params(), 64'h0001_000D_EFC0_0200);
        chk("rst_mid_flags", {60'd0, in_ready, params_ready, load_done, load_error}, 64'h8);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        @(posedge clk);
        #1;
        chk("rst_leftover_ignored", {params(), 6'd0, params_ready, load_done},
            {64'h0001_000D_EFC0_0200, 8'd0});
        run_frame("after_rst", 64'h0102_0304_0506_0708, 8'h08, 1'b1, 64'h0102_0304_0506_0708, 1'b1, 3, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (!reset && load_done && load_error) begin
            checks++;
            failures++;
            $display("FAIL pulse_exclusive actual=%b%b required=not both", load_done, load_error);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
